// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch redirect unit: default PC constants, instruction size and the
// fetch FSM state encoding.
package fetch_redirect_unit_pkg;

   localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
   localparam logic [31:0] DefaultMtvec   = 32'h0000_0100;
   localparam int unsigned InstrBytes     = 4;

   typedef enum logic [1:0] {
      StBoot,
      StRun,
      StDrain
   } fetch_state_t;

endpackage

// File: rtl/fetch_drop_counter.sv
// Wrong-path response drop counter. Loads Latency on a redirect, then counts down once per
// instruction-memory response until every response issued before the redirect has drained.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset (clears any pending drops)
//   load_i       redirect this cycle: reload the counter with Latency
//   resp_valid_i instruction-memory response valid this cycle
//   zero_o       no responses left to drop
module fetch_drop_counter #(
   parameter int unsigned Latency = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic resp_valid_i,
   output logic zero_o
);

   localparam int unsigned CntW = $clog2(Latency + 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   // A reload on a back-to-back redirect replaces the count rather than accumulating it: only
   // responses to addresses issued before the newest redirect are still wrong-path.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CntW'(Latency);
      end else if ((cnt_q != '0) && resp_valid_i) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch-side PC owner. Issues fetch addresses, redirects on a taken branch/jump resolved in EX,
// flushes IF/ID and ID/EX on the redirect edge and suppresses wrong-path memory responses.
//
// Optional build macro MISALIGN_TRAP_EN: a taken target with nonzero low bits sends the PC to
// MTVEC and pulses misalign_trap_o. Without it the low target bits are ignored and
// misalign_trap_o is tied low.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   stall_i              hazard hold: keep PC and re-issue the same address
//   ex_valid_i           EX holds a valid instruction
//   ex_is_branch_i       EX instruction is a conditional branch
//   ex_is_jump_i         EX instruction is JAL/JALR
//   branch_i             branch condition result
//   ex_target_i          branch/jump target from EX
//   imem_resp_valid_i    instruction-memory response valid
//   pc_o                 current fetch address
//   imem_req_o           fetch request strobe
//   fetch_valid_o        response is on the correct path
//   flush_if_id_o        clear IF/ID this edge
//   flush_id_ex_o        clear ID/EX this edge
//   redirect_taken_o     registered one-cycle pulse per redirect
//   misalign_trap_o      registered misaligned-target trap pulse
module fetch_redirect_unit
   import fetch_redirect_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = DefaultResetPc,
   parameter int unsigned IMEM_LATENCY = 1,
   parameter logic [31:0] MTVEC        = DefaultMtvec
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        ex_valid_i,
   input  logic        ex_is_branch_i,
   input  logic        ex_is_jump_i,
   input  logic        branch_i,
   input  logic [31:0] ex_target_i,
   input  logic        imem_resp_valid_i,
   output logic [31:0] pc_o,
   output logic        imem_req_o,
   output logic        fetch_valid_o,
   output logic        flush_if_id_o,
   output logic        flush_id_ex_o,
   output logic        redirect_taken_o,
   output logic        misalign_trap_o
);

   fetch_state_t state_d, state_q;
   logic [31:0]  pc_d, pc_q;
   logic [31:0]  redirect_pc;
   logic         take;
   logic         drop_zero;
   logic         redirect_taken_q;

   assign take = ex_valid_i & (ex_is_jump_i | (ex_is_branch_i & branch_i));

   // Flushes are combinational so the pipeline registers clear on the same edge the PC loads.
   assign flush_if_id_o = take;
   assign flush_id_ex_o = take;

`ifdef MISALIGN_TRAP_EN
   logic misaligned;
   logic misalign_trap_q;

   assign misaligned  = (ex_target_i[1:0] != 2'b00);
   assign redirect_pc = misaligned ? MTVEC : {ex_target_i[31:2], 2'b00};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         misalign_trap_q <= 1'b0;
      end else begin
         misalign_trap_q <= take & misaligned;
      end
   end

   assign misalign_trap_o = misalign_trap_q;
`else
   logic unused_trap_cfg;

   assign redirect_pc     = {ex_target_i[31:2], 2'b00};
   assign misalign_trap_o = 1'b0;
   assign unused_trap_cfg = ^{ex_target_i[1:0], MTVEC};
`endif

   // BOOT issues no request, so the PC is not advanced there; the first RUN cycle fetches
   // RESET_PC.
   always_comb begin
      pc_d = pc_q;
      if (take) begin
         pc_d = redirect_pc;
      end else if (!stall_i && (state_q != StBoot)) begin
         pc_d = pc_q + 32'(InstrBytes);
      end
   end

   always_comb begin
      state_d    = state_q;
      imem_req_o = 1'b0;
      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            imem_req_o = 1'b1;
            if (take) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            imem_req_o = 1'b1;
            if (!take && drop_zero) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q          <= StBoot;
         pc_q             <= RESET_PC;
         redirect_taken_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         redirect_taken_q <= take;
      end
   end

   fetch_drop_counter #(
      .Latency (IMEM_LATENCY)
   ) u_drop_counter (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (take),
      .resp_valid_i (imem_resp_valid_i),
      .zero_o       (drop_zero)
   );

   assign pc_o             = pc_q;
   assign redirect_taken_o = redirect_taken_q;
   assign fetch_valid_o    = imem_resp_valid_i & drop_zero & ~take;

endmodule
